// File: rtl/nes_mem_pkg.sv
// Shared definitions for the NES memory path: arbiter states, grant owners,
// SRAM layout defaults, region limits and the address translation helpers.
package nes_mem_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_PPU = 1'b1
  } owner_t;

  localparam logic [17:0] SRAM_PATTERN_START_DEFAULT = 18'h00000;
  localparam logic [17:0] SRAM_PROGRAM_START_DEFAULT = 18'h02000;

  localparam logic [15:0] PRG_BASE  = 16'h8000;
  localparam logic [13:0] CHR_LIMIT = 14'h2000;

  typedef struct packed {
    logic [15:0] addr;
    logic        rnw;
    logic [7:0]  wdata;
  } cpu_slot_t;

  // Offsets are taken relative to the region base so the region bit itself
  // drops out of the translated address.
  function automatic logic [17:0] prg_sram_addr(input logic [17:0] base,
                                                input logic [15:0] cpu_addr,
                                                input logic [14:0] mask);
    logic [15:0] offset;
    offset = (cpu_addr - PRG_BASE) & {1'b0, mask};
    return base + {2'b00, offset};
  endfunction

  function automatic logic [17:0] chr_sram_addr(input logic [17:0] base,
                                                input logic [13:0] ppu_addr);
    logic [13:0] offset;
    offset = ppu_addr & (CHR_LIMIT - 14'd1);
    return base + {4'b0000, offset};
  endfunction

endpackage

// File: rtl/req_slot.sv
// One-deep request holder: latches a request word and stays occupied until
// the arbiter frees it. A load on the freeing edge refills the slot.
module req_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             free,
  input  logic [WIDTH-1:0] load_data,
  output logic             occupied,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupied <= 1'b0;
      data     <= '0;
    end else if (load) begin
      occupied <= 1'b1;
      data     <= load_data;
    end else if (free) begin
      occupied <= 1'b0;
    end
  end

endmodule

// File: rtl/sram_request_arbiter.sv
// Round-robin arbiter between CPU PRG accesses and PPU pattern reads in front
// of the SRAM interface FSM; one SRAM transaction in flight at a time.
module sram_request_arbiter
  import nes_mem_pkg::*;
#(
  parameter logic [17:0] SRAM_PATTERN_START = SRAM_PATTERN_START_DEFAULT,
  parameter logic [17:0] SRAM_PROGRAM_START = SRAM_PROGRAM_START_DEFAULT,
  parameter logic [14:0] PRG_MASK           = 15'h7FFF,
  parameter bit          PRG_WRITABLE       = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_rnw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid,
  output logic        cpu_overrun,
  output logic        ready,
  input  logic        ppu_rd_req,
  input  logic [13:0] ppu_addr,
  output logic [7:0]  ppu_rdata,
  output logic        ppu_rvalid,
  output logic        sram_req,
  output logic        sram_rnw,
  output logic [17:0] sram_addr,
  output logic [7:0]  sram_wdata,
  input  logic        sram_ack,
  input  logic [7:0]  sram_rdata
);

  arb_state_t  state;
  owner_t      last_grant;
  owner_t      owner;

  cpu_slot_t   cpu_load_data;
  cpu_slot_t   cpu_slot_q;
  logic        cpu_occupied;
  logic [13:0] ppu_slot_q;
  logic        ppu_occupied;

  logic        cpu_in_region;
  logic        ppu_in_region;
  logic        busy_done;
  logic        grant_cpu;
  logic        grant_ppu;
  logic        cpu_drop;
  logic        cpu_free;
  logic        ppu_free;
  logic        cpu_load;
  logic        cpu_lost;
  logic        ppu_load;
  logic [17:0] cpu_sram_addr;
  logic [17:0] ppu_sram_addr;

  assign cpu_in_region = (cpu_addr >= PRG_BASE);
  assign ppu_in_region = (ppu_addr < CHR_LIMIT);
  assign busy_done     = (state == ARB_BUSY) && sram_ack;

  // The CPU wins a tie only when the PPU had the previous turn.
  assign grant_cpu = (state == ARB_IDLE) && cpu_occupied &&
                     (!ppu_occupied || (last_grant == OWNER_PPU));
  assign grant_ppu = (state == ARB_IDLE) && ppu_occupied && !grant_cpu;
  assign cpu_drop  = grant_cpu && !cpu_slot_q.rnw && !PRG_WRITABLE;

  assign cpu_free = (busy_done && (owner == OWNER_CPU)) || cpu_drop;
  assign ppu_free = busy_done && (owner == OWNER_PPU);

  // A strobe landing on the edge that frees its slot refills it directly.
  assign cpu_load = cpu_req && cpu_in_region && (!cpu_occupied || cpu_free);
  assign cpu_lost = cpu_req && cpu_in_region && cpu_occupied && !cpu_free;
  assign ppu_load = ppu_rd_req && ppu_in_region && (!ppu_occupied || ppu_free);

  assign cpu_load_data = {cpu_addr, cpu_rnw, cpu_wdata};

  assign cpu_sram_addr = prg_sram_addr(SRAM_PROGRAM_START, cpu_slot_q.addr, PRG_MASK);
  assign ppu_sram_addr = chr_sram_addr(SRAM_PATTERN_START, ppu_slot_q);

  req_slot #(
    .WIDTH($bits(cpu_slot_t))
  ) u_cpu_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (cpu_load),
    .free      (cpu_free),
    .load_data (cpu_load_data),
    .occupied  (cpu_occupied),
    .data      (cpu_slot_q)
  );

  req_slot #(
    .WIDTH(14)
  ) u_ppu_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (ppu_load),
    .free      (ppu_free),
    .load_data (ppu_addr),
    .occupied  (ppu_occupied),
    .data      (ppu_slot_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ARB_IDLE;
      last_grant  <= OWNER_PPU;
      owner       <= OWNER_CPU;
      sram_req    <= 1'b0;
      sram_rnw    <= 1'b0;
      sram_addr   <= '0;
      sram_wdata  <= '0;
      cpu_rdata   <= '0;
      cpu_rvalid  <= 1'b0;
      cpu_overrun <= 1'b0;
      ready       <= 1'b1;
      ppu_rdata   <= '0;
      ppu_rvalid  <= 1'b0;
    end else begin
      cpu_rvalid  <= 1'b0;
      ppu_rvalid  <= 1'b0;
      cpu_overrun <= cpu_lost;

      case (state)
        ARB_IDLE: begin
          if (cpu_drop) begin
            cpu_rvalid <= 1'b1;
            last_grant <= OWNER_CPU;
          end else if (grant_cpu) begin
            sram_req   <= 1'b1;
            sram_rnw   <= cpu_slot_q.rnw;
            sram_addr  <= cpu_sram_addr;
            sram_wdata <= cpu_slot_q.wdata;
            owner      <= OWNER_CPU;
            last_grant <= OWNER_CPU;
            state      <= ARB_BUSY;
          end else if (grant_ppu) begin
            sram_req   <= 1'b1;
            sram_rnw   <= 1'b1;
            sram_addr  <= ppu_sram_addr;
            sram_wdata <= '0;
            owner      <= OWNER_PPU;
            last_grant <= OWNER_PPU;
            state      <= ARB_BUSY;
          end
        end

        ARB_BUSY: begin
          if (sram_ack) begin
            sram_req <= 1'b0;
            state    <= ARB_IDLE;
            if (owner == OWNER_CPU) begin
              cpu_rvalid <= 1'b1;
              if (sram_rnw) begin
                cpu_rdata <= sram_rdata;
                ready     <= 1'b1;
              end
            end else begin
              ppu_rvalid <= 1'b1;
              ppu_rdata  <= sram_rdata;
            end
          end
        end

        default: state <= ARB_IDLE;
      endcase

      // Stall the CPU from the cycle after it issues a read.
      if (cpu_load && cpu_rnw) begin
        ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_request_arbiter.sv
// Directed bench for sram_request_arbiter: default build plus a second build
// with a 16 KB mirrored, writable PRG region.
module tb_sram_request_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_rnw;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        ppu_rd_req;
  logic [13:0] ppu_addr;
  logic        sram_ack;
  logic        alt_sram_ack;
  logic [7:0]  sram_rdata;

  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        cpu_overrun;
  logic        ready;
  logic [7:0]  ppu_rdata;
  logic        ppu_rvalid;
  logic        sram_req;
  logic        sram_rnw;
  logic [17:0] sram_addr;
  logic [7:0]  sram_wdata;

  logic [7:0]  alt_cpu_rdata;
  logic        alt_cpu_rvalid;
  logic        alt_cpu_overrun;
  logic        alt_ready;
  logic [7:0]  alt_ppu_rdata;
  logic        alt_ppu_rvalid;
  logic        alt_sram_req;
  logic        alt_sram_rnw;
  logic [17:0] alt_sram_addr;
  logic [7:0]  alt_sram_wdata;

  int tests_run;
  int tests_failed;
  int rvalid_count;

  sram_request_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_rnw     (cpu_rnw),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_overrun (cpu_overrun),
    .ready       (ready),
    .ppu_rd_req  (ppu_rd_req),
    .ppu_addr    (ppu_addr),
    .ppu_rdata   (ppu_rdata),
    .ppu_rvalid  (ppu_rvalid),
    .sram_req    (sram_req),
    .sram_rnw    (sram_rnw),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_ack    (sram_ack),
    .sram_rdata  (sram_rdata)
  );

  sram_request_arbiter #(
    .PRG_MASK     (15'h3FFF),
    .PRG_WRITABLE (1'b1)
  ) dut_alt (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_rnw     (cpu_rnw),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (alt_cpu_rdata),
    .cpu_rvalid  (alt_cpu_rvalid),
    .cpu_overrun (alt_cpu_overrun),
    .ready       (alt_ready),
    .ppu_rd_req  (ppu_rd_req),
    .ppu_addr    (ppu_addr),
    .ppu_rdata   (alt_ppu_rdata),
    .ppu_rvalid  (alt_ppu_rvalid),
    .sram_req    (alt_sram_req),
    .sram_rnw    (alt_sram_rnw),
    .sram_addr   (alt_sram_addr),
    .sram_wdata  (alt_sram_wdata),
    .sram_ack    (alt_sram_ack),
    .sram_rdata  (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Holds the given inputs across one rising edge, then drops every strobe.
  task automatic applyStimulus(input logic c_req, input logic c_rnw,
                               input logic [15:0] c_addr, input logic [7:0] c_wdata,
                               input logic p_req, input logic [13:0] p_addr,
                               input logic s_ack, input logic a_ack,
                               input logic [7:0] s_rdata);
    cpu_req      = c_req;
    cpu_rnw      = c_rnw;
    cpu_addr     = c_addr;
    cpu_wdata    = c_wdata;
    ppu_rd_req   = p_req;
    ppu_addr     = p_addr;
    sram_ack     = s_ack;
    alt_sram_ack = a_ack;
    sram_rdata   = s_rdata;
    @(posedge clk);
    #1;
    cpu_req      = 1'b0;
    ppu_rd_req   = 1'b0;
    sram_ack     = 1'b0;
    alt_sram_ack = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++)
      applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 14'h0000, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic cpu_access(input logic rnw, input logic [15:0] addr, input logic [7:0] wdata);
    applyStimulus(1'b1, rnw, addr, wdata, 1'b0, 14'h0000, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic ack(input logic [7:0] rdata);
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 14'h0000, 1'b1, 1'b0, rdata);
  endtask

  task automatic alt_ack(input logic [7:0] rdata);
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 14'h0000, 1'b0, 1'b1, rdata);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    cpu_req      = 1'b0;
    cpu_rnw      = 1'b0;
    cpu_addr     = 16'h0000;
    cpu_wdata    = 8'h00;
    ppu_rd_req   = 1'b0;
    ppu_addr     = 14'h0000;
    sram_ack     = 1'b0;
    alt_sram_ack = 1'b0;
    sram_rdata   = 8'h00;

    @(posedge clk);
    #1;
    checkOutput("rst_ready",     32'(ready), 32'd1);
    checkOutput("rst_sram_req",  32'(sram_req), 32'd0);
    checkOutput("rst_sram_addr", 32'(sram_addr), 32'd0);
    checkOutput("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    checkOutput("rst_ppu_rvalid", 32'(ppu_rvalid), 32'd0);
    checkOutput("rst_overrun",   32'(cpu_overrun), 32'd0);
    checkOutput("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    rst = 1'b1;

    // CPU read $C123 -> SRAM 0x06123
    cpu_access(1'b1, 16'hC123, 8'h00);
    checkOutput("t1_ready_low", 32'(ready), 32'd0);
    checkOutput("t1_no_req_yet", 32'(sram_req), 32'd0);
    idle(1);
    checkOutput("t1_sram_req",  32'(sram_req), 32'd1);
    checkOutput("t1_sram_addr", 32'(sram_addr), 32'h06123);
    checkOutput("t1_sram_rnw",  32'(sram_rnw), 32'd1);
    checkOutput("t1_ready_busy", 32'(ready), 32'd0);
    idle(1);
    checkOutput("t1_hold_req",  32'(sram_req), 32'd1);
    checkOutput("t1_hold_addr", 32'(sram_addr), 32'h06123);
    checkOutput("t1_no_rvalid", 32'(cpu_rvalid), 32'd0);
    ack(8'hA5);
    checkOutput("t1_rvalid",   32'(cpu_rvalid), 32'd1);
    checkOutput("t1_rdata",    32'(cpu_rdata), 32'hA5);
    checkOutput("t1_ready_up", 32'(ready), 32'd1);
    checkOutput("t1_req_drop", 32'(sram_req), 32'd0);
    idle(1);
    checkOutput("t1_rvalid_once", 32'(cpu_rvalid), 32'd0);
    checkOutput("t1_rdata_hold",  32'(cpu_rdata), 32'hA5);

    // Simultaneous strobes after reset: CPU first, then the refilled CPU slot loses the tie
    do_reset();
    applyStimulus(1'b1, 1'b1, 16'h8000, 8'h00, 1'b1, 14'h0010, 1'b0, 1'b0, 8'h00);
    idle(1);
    checkOutput("t2_cpu_first", 32'(sram_addr), 32'h02000);
    checkOutput("t2_cpu_req",   32'(sram_req), 32'd1);
    applyStimulus(1'b1, 1'b1, 16'h8001, 8'h00, 1'b0, 14'h0000, 1'b1, 1'b0, 8'h11);
    checkOutput("t2_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    checkOutput("t2_cpu_rdata",  32'(cpu_rdata), 32'h11);
    checkOutput("t2_refill_no_overrun", 32'(cpu_overrun), 32'd0);
    idle(1);
    checkOutput("t2_ppu_second", 32'(sram_addr), 32'h00010);
    checkOutput("t2_ppu_rnw",    32'(sram_rnw), 32'd1);
    ack(8'h3C);
    checkOutput("t2_ppu_rvalid", 32'(ppu_rvalid), 32'd1);
    checkOutput("t2_ppu_rdata",  32'(ppu_rdata), 32'h3C);
    checkOutput("t2_cpu_quiet",  32'(cpu_rvalid), 32'd0);
    idle(1);
    checkOutput("t2_cpu_third",  32'(sram_addr), 32'h02001);
    ack(8'h22);
    checkOutput("t2_cpu_rdata2", 32'(cpu_rdata), 32'h22);
    checkOutput("t2_ppu_hold",   32'(ppu_rdata), 32'h3C);
    idle(1);

    // Out-of-range strobes are ignored
    applyStimulus(1'b1, 1'b1, 16'h2002, 8'h00, 1'b1, 14'h2400, 1'b0, 1'b0, 8'h00);
    idle(1);
    checkOutput("t5_oor_req", 32'(sram_req), 32'd0);
    checkOutput("t5_oor_overrun", 32'(cpu_overrun), 32'd0);
    idle(1);
    checkOutput("t5_oor_req2", 32'(sram_req), 32'd0);
    checkOutput("t5_oor_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    checkOutput("t5_oor_ppu_rvalid", 32'(ppu_rvalid), 32'd0);

    // Second CPU strobe while the first is in flight
    cpu_access(1'b1, 16'h8100, 8'h00);
    idle(1);
    checkOutput("t5_inflight_addr", 32'(sram_addr), 32'h02100);
    cpu_access(1'b1, 16'h8200, 8'h00);
    checkOutput("t5_overrun", 32'(cpu_overrun), 32'd1);
    idle(1);
    checkOutput("t5_overrun_once", 32'(cpu_overrun), 32'd0);
    rvalid_count = 0;
    ack(8'h5A);
    rvalid_count += 32'(cpu_rvalid);
    checkOutput("t5_rdata", 32'(cpu_rdata), 32'h5A);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      rvalid_count += 32'(cpu_rvalid);
    end
    checkOutput("t5_one_rvalid", 32'(rvalid_count), 32'd1);
    checkOutput("t5_no_second_txn", 32'(sram_req), 32'd0);

    // Dropped CPU write on the read-only build
    cpu_access(1'b0, 16'h9000, 8'h55);
    checkOutput("t4_wr_ready", 32'(ready), 32'd1);
    checkOutput("t4_wr_noreq", 32'(sram_req), 32'd0);
    idle(1);
    checkOutput("t4_wr_rvalid", 32'(cpu_rvalid), 32'd1);
    checkOutput("t4_wr_noreq2", 32'(sram_req), 32'd0);
    checkOutput("t4_wr_ready2", 32'(ready), 32'd1);
    checkOutput("t4_wr_rdata_hold", 32'(cpu_rdata), 32'h5A);
    idle(1);
    checkOutput("t4_wr_rvalid_once", 32'(cpu_rvalid), 32'd0);
    checkOutput("t4_wr_noreq3", 32'(sram_req), 32'd0);

    // Reset while BUSY with the ack withheld
    cpu_access(1'b1, 16'hA000, 8'h00);
    idle(1);
    checkOutput("t6_busy_req",  32'(sram_req), 32'd1);
    checkOutput("t6_busy_addr", 32'(sram_addr), 32'h04000);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t6_async_req_drop", 32'(sram_req), 32'd0);
    checkOutput("t6_async_ready",    32'(ready), 32'd1);
    idle(2);
    checkOutput("t6_no_rvalid", 32'(cpu_rvalid), 32'd0);
    rst = 1'b1;
    idle(1);
    checkOutput("t6_no_rvalid_after", 32'(cpu_rvalid), 32'd0);
    checkOutput("t6_idle_after", 32'(sram_req), 32'd0);
    cpu_access(1'b1, 16'h8003, 8'h00);
    idle(1);
    checkOutput("t6_new_addr", 32'(sram_addr), 32'h02003);
    checkOutput("t6_new_req",  32'(sram_req), 32'd1);
    ack(8'h99);
    checkOutput("t6_new_rvalid", 32'(cpu_rvalid), 32'd1);
    checkOutput("t6_new_rdata",  32'(cpu_rdata), 32'h99);
    checkOutput("t6_new_ready",  32'(ready), 32'd1);

    // Mirrored, writable PRG build
    do_reset();
    cpu_access(1'b1, 16'hC005, 8'h00);
    idle(1);
    checkOutput("t3_mirror_hi", 32'(alt_sram_addr), 32'h02005);
    checkOutput("t3_mirror_req", 32'(alt_sram_req), 32'd1);
    alt_ack(8'h44);
    checkOutput("t3_alt_rdata", 32'(alt_cpu_rdata), 32'h44);
    idle(1);
    cpu_access(1'b1, 16'h8005, 8'h00);
    idle(1);
    checkOutput("t3_mirror_lo", 32'(alt_sram_addr), 32'h02005);
    alt_ack(8'h45);
    checkOutput("t3_alt_rdata2", 32'(alt_cpu_rdata), 32'h45);
    idle(1);
    cpu_access(1'b0, 16'h9000, 8'h55);
    checkOutput("t4_alt_ready", 32'(alt_ready), 32'd1);
    idle(1);
    checkOutput("t4_alt_req",   32'(alt_sram_req), 32'd1);
    checkOutput("t4_alt_rnw",   32'(alt_sram_rnw), 32'd0);
    checkOutput("t4_alt_wdata", 32'(alt_sram_wdata), 32'h55);
    checkOutput("t4_alt_addr",  32'(alt_sram_addr), 32'h03000);
    alt_ack(8'hEE);
    checkOutput("t4_alt_rvalid", 32'(alt_cpu_rvalid), 32'd1);
    checkOutput("t4_alt_ready2", 32'(alt_ready), 32'd1);
    checkOutput("t4_alt_rdata_hold", 32'(alt_cpu_rdata), 32'h45);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sram_request_arbiter.md
Name: sram_request_arbiter

Overview:
- Sits directly upstream of the SRAM interface FSM. Accepts CPU PRG-ROM/RAM accesses ($8000-$FFFF) and PPU pattern-table reads ($0000-$1FFF).
- Holds one pending slot per requester and arbitrates round-robin. Translates each access into an 18-bit SRAM byte address and issues one transaction at a time over a req/ack handshake.
- Returns read data to the winning requester and drives the CPU `ready` stall.

Parameters:
- SRAM_PATTERN_START, 18'h00000: SRAM byte base of CHR (pattern) data.
- SRAM_PROGRAM_START, 18'h02000: SRAM byte base of PRG data.
- PRG_MASK, 15'h7FFF: applied to cpu_addr[14:0]. Use 15'h3FFF for 16 KB mirrored PRG.
- PRG_WRITABLE, 0: 1 = CPU writes go to SRAM; 0 = CPU writes are dropped.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  one-cycle access strobe
- cpu_rnw  in  1  1 = read, 0 = write
- cpu_addr  in  16  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  CPU read data
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid, or dropped write done
- cpu_overrun  out  1  one-cycle pulse: cpu_req lost
- ready  out  1  low = CPU must stall
- ppu_rd_req  in  1  one-cycle pattern read strobe
- ppu_addr  in  14  PPU address
- ppu_rdata  out  8  PPU read data
- ppu_rvalid  out  1  one-cycle pulse: ppu_rdata valid
- sram_req  out  1  transaction request to SRAM FSM
- sram_rnw  out  1  transaction direction
- sram_addr  out  18  SRAM byte address
- sram_wdata  out  8  SRAM write data
- sram_ack  in  1  one-cycle: transaction complete
- sram_rdata  in  8  read data, valid with sram_ack

Behaviour:

Reset (rst = 0, asynchronous):
- All outputs 0 except ready = 1.
- Both pending slots empty, FSM in IDLE, last_grant = PPU, so the CPU wins the first tie.
- Reset mid-transaction drops sram_req immediately. No rvalid is ever produced for the aborted access.

Acceptance:
- cpu_req is accepted only when cpu_addr[15] = 1. Otherwise it is ignored: no pending entry, no pulse.
- ppu_rd_req is accepted only when ppu_addr[13] = 0. Otherwise it is ignored.
- An accepted strobe latches addr/rnw/wdata into that requester's slot at the sampling edge.
- A strobe arriving while its own slot is already occupied (pending or in flight) is discarded:
  - CPU: cpu_overrun pulses on the next cycle.
  - PPU: discarded silently.

Address translation (18-bit, wraps modulo 2^18):
- PPU: SRAM_PATTERN_START + ppu_addr[12:0].
- CPU: SRAM_PROGRAM_START + (cpu_addr[14:0] & PRG_MASK).

FSM states:
- IDLE:
  - No slot pending: stay in IDLE.
  - One slot pending: grant it.
  - Both pending: grant the requester opposite last_grant.
  - A dropped write (PRG_WRITABLE = 0, CPU write) is retired in IDLE without an SRAM access. cpu_rvalid pulses next cycle. It consumes the grant turn.
  - A normal grant registers sram_req = 1 plus addr/rnw/wdata, updates last_grant, and goes to BUSY.
- BUSY:
  - sram_req, sram_addr, sram_rnw and sram_wdata are held stable until sram_ack is sampled.
  - On ack: sram_req <= 0, the slot is freed, and for reads the owner's rdata <= sram_rdata.
  - The owner's rvalid pulses for exactly one cycle. CPU writes also pulse cpu_rvalid.
  - Return to IDLE.
- sram_ack while in IDLE is ignored.
- A request strobe arriving on the same edge the slot frees is accepted, not an overrun.

Latency:
- Strobe sampled at edge E0; sram_req high after E1.
- With sram_ack at E2, rvalid is high in the cycle after E2.
- Minimum request-to-data time is 2 cycles. No back-to-back grants: each transaction spends at least 1 cycle in IDLE.

ready:
- Low from the cycle after an accepted CPU read until the cycle cpu_rvalid is high. ready returns high in that same cycle.
- CPU writes never lower ready.

Data hold:
- cpu_rdata and ppu_rdata hold their value until the next read completion for that requester.

Decomposition:
- Shared package (nes_mem_pkg):
  - FSM state encoding (ARB_IDLE, ARB_BUSY).
  - Grant-owner constants (OWNER_CPU, OWNER_PPU).
  - Default SRAM base constants, also used by the SRAM interface FSM.
  - Region boundary constants (PRG_BASE 16'h8000, CHR_LIMIT 14'h2000).
- One natural sub-module, `req_slot`: a 1-deep latched request holder with occupied flag, load and free. Instantiated twice (CPU: 16+1+8 bits, PPU: 14 bits).

Test Plan:
1. Reset then CPU read: cpu_req, rnw = 1, cpu_addr = 16'hC123, defaults -> sram_addr = 18'h06123, sram_rnw = 1; ack with sram_rdata = 8'hA5 -> cpu_rvalid one cycle, cpu_rdata = 8'hA5; ready low until that cycle.
2. Simultaneous cpu_req ($8000) and ppu_rd_req ($0010) after reset -> CPU granted first (sram_addr = 18'h02000), PPU second (sram_addr = 18'h00010); next tie goes to the PPU.
3. PRG_MASK = 15'h3FFF, CPU reads $C005 and $8005 -> both give sram_addr = 18'h02005.
4. PRG_WRITABLE = 0, CPU write $9000 = 8'h55 -> sram_req stays 0, cpu_rvalid pulses, ready stays 1. PRG_WRITABLE = 1 -> sram_rnw = 0, sram_wdata = 8'h55.
5. Out-of-range and overrun cases:
   - cpu_req at $2002 and ppu_rd_req at $2400 -> no activity.
   - A second cpu_req while the first is in flight -> cpu_overrun pulses; exactly one cpu_rvalid follows.
6. rst asserted while BUSY with sram_ack withheld -> sram_req drops asynchronously, ready = 1, no rvalid; a new request after release is served normally.
